pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 124 ++++++++++++
 tb/tb_pipelined_adder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: sliced add/subtract pipeline with valid/ready handshake.
// Each of STAGES stages adds one WIDTH/STAGES-bit slice. The carry is
// registered between stages, and the upper operand slices are delayed
// alongside the partial sum. The whole pipe advances as one unit whenever
// the output register is empty or is being drained.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic adv;

    // A single advance signal moves every stage, so no per-stage stall logic is needed.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Inputs to this stage: the ports for stage 0, otherwise the previous stage's registers.
        logic             v_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] bp_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;

        // Combinational slice result.
        logic [SW:0]      slice_sum;
        logic [WIDTH-1:0] s_nxt;

        // Stage registers.
        logic             v_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] bp_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;

        if (k == 0) begin : g_head
            // Subtraction becomes a + ~b with the +1 supplied as the carry into slice 0.
            assign v_in  = in_valid;
            assign a_in  = a;
            assign bp_in = sub ? ~b : b;
            assign s_in  = '0;
            assign c_in  = sub;
        end else begin : g_body
            assign v_in  = g_stage[k-1].v_q;
            assign a_in  = g_stage[k-1].a_q;
            assign bp_in = g_stage[k-1].bp_q;
            assign s_in  = g_stage[k-1].s_q;
            assign c_in  = g_stage[k-1].c_q;
        end

        assign slice_sum = {1'b0, a_in[k*SW +: SW]}
                         + {1'b0, bp_in[k*SW +: SW]}
                         + {{SW{1'b0}}, c_in};

        // Merge this stage's slice into the partial sum carried down the pipe.
        always_comb begin
            // NOTE: default first, then override -- every path assigns s_nxt, so no latch is inferred.
            s_nxt              = s_in;
            s_nxt[k*SW +: SW]  = slice_sum[SW-1:0];
        end

        // Advance the stage together with the rest of the pipe. Data loads only behind a valid op, so a bubble leaves the data untouched.
        always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: the pipeline registers are few and must read 0 the instant reset asserts, so every one of them is reset, data included.
            if (!rst_n) begin
                v_q  <= 1'b0;
                a_q  <= '0;
                bp_q <= '0;
                s_q  <= '0;
                c_q  <= 1'b0;
            end else if (adv) begin
                // NOTE: non-blocking assignments let every stage sample its predecessor's old value on the same edge.
                v_q <= v_in;
                if (v_in) begin
                    a_q  <= a_in;
                    bp_q <= bp_in;
                    s_q  <= s_nxt;
                    c_q  <= slice_sum[SW];
                end
            end
        end

        // Slices already consumed, and the final stage's operand copies, feed nothing downstream.
        logic unused_ok;
        assign unused_ok = ^{a_q, bp_q};
    end

    assign out_valid = g_stage[LAST].v_q;
    assign y         = g_stage[LAST].s_q;
    assign carry     = g_stage[LAST].c_q;

    // Flags are registered with the final sum so that they clear on reset and hold during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
        end else if (adv && g_stage[LAST].v_in) begin
            overflow <= (g_stage[LAST].a_in[WIDTH-1] == g_stage[LAST].bp_in[WIDTH-1])
                     && (g_stage[LAST].s_nxt[WIDTH-1] != g_stage[LAST].a_in[WIDTH-1]);
            zero     <= (g_stage[LAST].s_nxt == '0);
            negative <= g_stage[LAST].s_nxt[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: randomized and directed checks of pipelined_adder
// (WIDTH=8, STAGES=2) against an arithmetic reference model and an in-order
// scoreboard.
module tb_pipelined_adder;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .negative (negative)
    );

    typedef struct {
        logic [W-1:0] y;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        int           t;
    } exp_t;

    exp_t q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   tick_n  = 0;
    bit   lat_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain-integer reference: unsigned result gives y and carry; signed result gives overflow.
    function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                   input logic si, input int t);
        exp_t e;
        int   u;
        int   r;
        int   sa;
        int   sb;
        sa = int'($signed(ai));
        sb = int'($signed(bi));
        if (si) begin
            u = int'(ai) - int'(bi) + 256;
            r = sa - sb;
        end else begin
            u = int'(ai) + int'(bi);
            r = sa + sb;
        end
        e.y = W'(u % 256);
        e.c = (u >= 256);
        e.v = (r > 127) || (r < -128);
        e.z = (e.y == 0);
        e.n = e.y[W-1];
        e.t = t;
        return e;
    endfunction

    // Drive one cycle's inputs at the falling edge, check outputs, then let the rising edge pass.
    task automatic tick(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic is, input logic ordy);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sub       = is;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !out_valid || ordy);
        if (out_valid && !ordy) check("stall_in_ready", in_ready, 0);
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", out_valid, 0);
            end else begin
                check("y", y, q[0].y);
                check("carry", carry, q[0].c);
                check("overflow", overflow, q[0].v);
                check("zero", zero, q[0].z);
                check("negative", negative, q[0].n);
                if (ordy) begin
                    if (lat_chk) check("latency", tick_n - q[0].t, S);
                    void'(q.pop_front());
                end
            end
        end
        if (iv && in_ready) q.push_back(model(ia, ib, is, tick_n));
        @(negedge clk);
        tick_n++;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_carry"}, carry, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_zero"}, zero, 0);
        check({tag, "_negative"}, negative, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        #1;
        check_cleared("reset");
        @(negedge clk);
        @(negedge clk);
        check_cleared("reset_held");

        // Release reset and accept on the very first rising edge; directed corner cases then random back-to-back.
        rst_n   = 1'b1;
        lat_chk = 1'b1;
        tick(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1);
        tick(1'b1, 8'h05, 8'h05, 1'b1, 1'b1);
        tick(1'b1, 8'h03, 8'h05, 1'b1, 1'b1);
        tick(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
        tick(1'b1, 8'h80, 8'h80, 1'b1, 1'b1);
        tick(1'b1, 8'h05, 8'h80, 1'b1, 1'b1);
        tick(1'b1, 8'h80, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++)
            tick(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 4; i++)
            tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("directed_drained", q.size(), 0);

        // Stall with two ops in flight, inputs still offered, then release.
        lat_chk = 1'b0;
        tick(1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
        tick(1'b1, 8'h50, 8'h60, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++)
            tick(1'b1, 8'hAA, 8'h55, 1'b0, 1'b0);
        check("stall_held_ops", q.size(), 2);
        for (int i = 0; i < 4; i++)
            tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("stall_drained", q.size(), 0);

        // Reset mid-flight: outputs clear at once, and no stale result may appear afterwards.
        tick(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
        tick(1'b1, 8'h33, 8'h44, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_cleared("midreset");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 300; i++)
            tick(1'($urandom_range(0, 9) < 7), W'($urandom), W'($urandom),
                 1'($urandom), 1'($urandom_range(0, 9) < 6));
        for (int i = 0; i < 20 && q.size() != 0; i++)
            tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("drain_left", q.size(), 0);
        tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        check("idle_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
